serial_frame_rx: RTL

- Receiving end of the team's 1-bit serial shift path: recovers framed words from a bit-per-clock serial line and presents them as parallel data with a valid/ack handshake.
- Sits downstream of a serial shift register chain or transmitter that drives one bit per rising clock edge, with each bit stable across the sampling edge.
- Checks frame format (start/parity/stop) and flags errors and overruns.

---
 rtl/serial_frame_pkg.sv | 25 ++
 rtl/serial_shift_in.sv | 39 +++
 rtl/serial_frame_rx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/serial_frame_pkg.sv
// Purpose : shared types and constants for the framed serial receiver.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
// Contents: state_t FSM encoding, line-level constants, even-parity check helper.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    PAR  = 3'd2,
    STOP = 3'd3,
    BRK  = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Even parity holds when the XOR of all data bits equals the parity bit,
  // i.e. data bits plus parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic data_xor, input logic par_bit);
    return ~(data_xor ^ par_bit);
  endfunction

endpackage

// File: rtl/serial_shift_in.sv
// Purpose : LSB-first shift-in register with running XOR over the shifted bits.
// Latency : each enabled bit lands in o_data/o_par on the next rising edge.
// Backpr. : none; shifts whenever i_shift_en is high.
// Ports   : i_clk, i_rst_n (async active-low), i_clr (sync clear, start bit),
//           i_shift_en, i_bit -> o_data[WIDTH-1:0], o_par (XOR of shifted bits).
module serial_shift_in #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_shift_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data,
  output logic             o_par
);

  logic [WIDTH-1:0] r_data;
  logic             r_par;

  // New bits enter at the MSB and move down, so after WIDTH shifts the
  // first bit received sits in bit 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_par  <= 1'b0;
    end else if (i_clr) begin
      r_data <= '0;
      r_par  <= 1'b0;
    end else if (i_shift_en) begin
      r_data <= {i_bit, r_data[WIDTH-1:1]};
      r_par  <= r_par ^ i_bit;
    end
  end

  assign o_data = r_data;
  assign o_par  = r_par;

endmodule

// File: rtl/serial_frame_rx.sv
// Purpose : receive start/data/parity/stop framed words from a 1-bit line, present them with valid/ack.
// Latency : word visible on data_out/valid one cycle after its stop bit is sampled.
// Backpr. : no stall; a good word arriving while valid&&!ack is dropped and overrun is set (sticky until ack).
// Ports   : clock, clear (async active-low), A (serial line), ack ->
//           data_out[WIDTH-1:0], valid, busy, parity_err/frame_err (1-cycle pulses), overrun.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             A,
  input  logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_shift_en;
  logic             w_clr;
  logic             r_par_bit;
  logic [WIDTH-1:0] w_shift_data;
  logic             w_data_xor;
  logic             w_par_ok;
  logic             w_stop_edge;
  logic             w_good;
  logic             w_bad_par;
  logic             w_bad_stop;

  logic [WIDTH-1:0] r_data_out;
  logic             r_valid;
  logic             r_parity_err;
  logic             r_frame_err;
  logic             r_overrun;

  serial_shift_in #(.WIDTH(WIDTH)) u_shift (
    .i_clk      (clock),
    .i_rst_n    (clear),
    .i_clr      (w_clr),
    .i_shift_en (w_shift_en),
    .i_bit      (A),
    .o_data     (w_shift_data),
    .o_par      (w_data_xor)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_en  = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (A == START_BIT) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
        end
      end
      DATA: begin
        w_shift_en = 1'b1;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = (PARITY_EN != 0) ? PAR : STOP;
        end
      end
      PAR:  w_state_nxt = STOP;
      STOP: w_state_nxt = (A == STOP_BIT) ? IDLE : BRK;
      // Wait for the line to return high so a held-low line is not read as a new start bit.
      BRK: begin
        if (A == LINE_IDLE) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_par_bit <= 1'b0;
    end else if (r_state == PAR) begin
      r_par_bit <= A;
    end
  end

  assign w_par_ok    = (PARITY_EN == 0) || even_parity_ok(w_data_xor, r_par_bit);
  assign w_stop_edge = (r_state == STOP);
  assign w_good      = w_stop_edge && (A == STOP_BIT) && w_par_ok;
  // A zero stop bit is a framing error regardless of parity.
  assign w_bad_par   = w_stop_edge && (A == STOP_BIT) && !w_par_ok;
  assign w_bad_stop  = w_stop_edge && (A != STOP_BIT);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_data_out   <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_parity_err <= w_bad_par;
      r_frame_err  <= w_bad_stop;
      // Consumer takes the word; a delivery on the same edge overrides valid below.
      if (r_valid && ack) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
      if (w_good) begin
        if (!r_valid || ack) begin
          r_data_out <= w_shift_data;
          r_valid    <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end
    end
  end

  assign data_out   = r_data_out;
  assign valid      = r_valid;
  assign busy       = (r_state != IDLE);
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule
